// File: rtl/cdma_ctrl.sv
// Frame sequencer for the CDMA spreader: seed load, chip-rate pacing and per-bit handshake.
// Optional one-bit all-ones preamble after the seed load is enabled by defining CDMA_CTRL_PREAMBLE_EN.
module cdma_ctrl #(
  parameter int CLK_DIV        = 2,
  parameter int CHIPS_PER_BIT  = 15,
  parameter int BITS_PER_FRAME = 8
) (
  input  logic                              clk_i,
  input  logic                              set_i,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [3:0]                        seed_i,
  input  logic                              bit_i,
  input  logic                              bit_valid_i,
  output logic                              bit_ready_o,
  output logic [3:0]                        seed_o,
  output logic                              seed_load_o,
  output logic                              chip_en_o,
  output logic                              bit_o,
  output logic [$clog2(CHIPS_PER_BIT)-1:0]  chip_idx_o,
  output logic [$clog2(BITS_PER_FRAME)-1:0] bit_idx_o,
  output logic                              busy_o,
  output logic                              frame_done_o,
  output logic                              led_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(CHIPS_PER_BIT);
  localparam int BW = $clog2(BITS_PER_FRAME);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(CHIPS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_FRAME - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [CW-1:0] CHIP_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef CDMA_CTRL_PREAMBLE_EN
    S_PRE   = 3'd2,
`endif
    S_FETCH = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   chip_q, chip_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic            bit_q, bit_d;
  logic [3:0]      seed_q, seed_d;
  logic            led_q, led_d;

  logic            seed_load;
  logic            bit_ready;
  logic            chip_en;
  logic            frame_done;

  always_ff @(posedge clk_i) begin
    if (set_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      chip_q    <= '0;
      bit_idx_q <= '0;
      bit_q     <= 1'b0;
      seed_q    <= '0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      chip_q    <= chip_d;
      bit_idx_q <= bit_idx_d;
      bit_q     <= bit_d;
      seed_q    <= seed_d;
      led_q     <= led_d;
    end
  end

  // Bit handshake: bit_ready_o is high only in FETCH (and not while aborting);
  // a bit transfers on any cycle with bit_valid_i && bit_ready_o, and valid never waits on ready.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    chip_d     = chip_q;
    bit_idx_d  = bit_idx_q;
    bit_d      = bit_q;
    seed_d     = seed_q;
    led_d      = led_q;
    seed_load  = 1'b0;
    bit_ready  = 1'b0;
    chip_en    = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          seed_d    = seed_i;
          bit_idx_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        seed_load = 1'b1;
`ifdef CDMA_CTRL_PREAMBLE_EN
        bit_d   = 1'b1;
        div_d   = '0;
        chip_d  = '0;
        state_d = S_PRE;
`else
        state_d = S_FETCH;
`endif
      end
      S_FETCH: begin
        bit_ready = 1'b1;
        if (bit_valid_i) begin
          bit_d   = bit_i;
          div_d   = '0;
          chip_d  = '0;
          state_d = S_RUN;
        end
      end
`ifdef CDMA_CTRL_PREAMBLE_EN
      S_RUN, S_PRE: begin
`else
      S_RUN: begin
`endif
        if (div_q == DIV_LAST) begin
          chip_en = 1'b1;
          div_d   = '0;
          if (chip_q == CHIP_LAST) begin
            chip_d = '0;
`ifdef CDMA_CTRL_PREAMBLE_EN
            if (state_q == S_PRE) state_d = S_FETCH;
            else
`endif
            if (bit_idx_q == BIT_LAST) begin
              state_d = S_DONE;
            end else begin
              bit_idx_d = bit_idx_q + BIT_ONE;
              state_d   = S_FETCH;
            end
          end else begin
            chip_d = chip_q + CHIP_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        led_d      = ~led_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort cancels the frame outright: no strobes this cycle and every datapath register holds.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      div_d      = div_q;
      chip_d     = chip_q;
      bit_idx_d  = bit_idx_q;
      bit_d      = bit_q;
      led_d      = led_q;
      seed_load  = 1'b0;
      bit_ready  = 1'b0;
      chip_en    = 1'b0;
      frame_done = 1'b0;
    end
  end

  assign bit_ready_o  = bit_ready;
  assign seed_o       = seed_q;
  assign seed_load_o  = seed_load;
  assign chip_en_o    = chip_en;
  assign bit_o        = bit_q;
  assign chip_idx_o   = chip_q;
  assign bit_idx_o    = bit_idx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = frame_done;
  assign led_o        = led_q;

endmodule

// File: tb/tb_cdma_ctrl.sv
// Bench for cdma_ctrl: directed frame tables, multi-cycle corner sequences and a random run
// against a timeline model built from bit-period arithmetic.
module tb_cdma_ctrl;

  localparam int D = 2;
  localparam int C = 15;
  localparam int B = 8;
`ifdef CDMA_CTRL_PREAMBLE_EN
  localparam int P = D * C;
`else
  localparam int P = 0;
`endif
  localparam logic PB = (P != 0);

  logic       clk;
  logic       set_i, start_i, abort_i, bit_i, bit_valid_i;
  logic [3:0] seed_i;
  logic       bit_ready_o, seed_load_o, chip_en_o, bit_o, busy_o, frame_done_o, led_o;
  logic [3:0] seed_o;
  logic [3:0] chip_idx_o;
  logic [2:0] bit_idx_o;
  logic [17:0] dut_vec;

  cdma_ctrl #(.CLK_DIV(D), .CHIPS_PER_BIT(C), .BITS_PER_FRAME(B)) dut (
    .clk_i(clk), .set_i(set_i), .start_i(start_i), .abort_i(abort_i),
    .seed_i(seed_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .bit_ready_o(bit_ready_o), .seed_o(seed_o), .seed_load_o(seed_load_o),
    .chip_en_o(chip_en_o), .bit_o(bit_o), .chip_idx_o(chip_idx_o),
    .bit_idx_o(bit_idx_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .led_o(led_o)
  );

  assign dut_vec = {busy_o, seed_load_o, bit_ready_o, chip_en_o, frame_done_o, bit_o, led_o,
                    chip_idx_o, bit_idx_o, seed_o};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic ab, input logic [3:0] sd,
                       input logic b, input logic v);
    set_i = s; start_i = st; abort_i = ab; seed_i = sd; bit_i = b; bit_valid_i = v;
  endtask

  // nominal-frame expectation table
  typedef struct {
    int         r;
    logic       busy, sl, rdy, ce, fd, bo, led;
    logic [3:0] ci;
    logic [2:0] bi;
    logic [3:0] seed;
  } vec_t;
  vec_t tbl[11];

  task automatic check_row(input vec_t v);
    chk("nom_busy", busy_o, v.busy);
    chk("nom_seed_load", seed_load_o, v.sl);
    chk("nom_bit_ready", bit_ready_o, v.rdy);
    chk("nom_chip_en", chip_en_o, v.ce);
    chk("nom_frame_done", frame_done_o, v.fd);
    chk("nom_bit_o", bit_o, v.bo);
    chk("nom_led", led_o, v.led);
    chk("nom_chip_idx", chip_idx_o, v.ci);
    chk("nom_bit_idx", bit_idx_o, v.bi);
    chk("nom_seed", seed_o, v.seed);
  endtask

  // Timeline model: phase plus cycles elapsed inside the current bit period.
  // 0 idle, 1 load, 2 preamble, 3 fetch, 4 run, 5 done
  int         m_ph, m_t, m_chip, m_bi;
  logic       m_bit, m_led;
  logic [3:0] m_seed;

  function automatic logic [17:0] m_out(input logic ab);
    logic act, ce;
    act = (m_ph != 0) && !ab;
    ce  = act && (m_ph == 2 || m_ph == 4) && ((m_t % D) == D - 1);
    return {m_ph != 0, act && m_ph == 1, act && m_ph == 3, ce, act && m_ph == 5,
            m_bit, m_led, 4'(m_chip), 3'(m_bi), m_seed};
  endfunction

  task automatic m_step(input logic s, input logic st, input logic ab, input logic [3:0] sd,
                        input logic b, input logic v);
    if (s) begin
      m_ph = 0; m_t = 0; m_chip = 0; m_bi = 0; m_bit = 0; m_led = 0; m_seed = 0;
    end else if (m_ph != 0 && ab) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (st) begin m_seed = sd; m_bi = 0; m_ph = 1; end
        1: if (P != 0) begin m_ph = 2; m_t = 0; m_chip = 0; m_bit = 1; end else m_ph = 3;
        3: if (v) begin m_bit = b; m_t = 0; m_chip = 0; m_ph = 4; end
        2, 4: begin
          m_t++;
          m_chip = (m_t / D) % C;
          if (m_t == D * C) begin
            if (m_ph == 2) m_ph = 3;
            else if (m_bi == B - 1) m_ph = 5;
            else begin m_bi++; m_ph = 3; end
          end
        end
        default: begin m_led = ~m_led; m_ph = 0; end
      endcase
    end
  endtask

  int         idx, ce_cnt, fd_cnt, win_cnt;
  logic [7:0] bits;
  logic       r_set, r_st, r_ab, r_b, r_v;
  logic [3:0] r_sd;

  initial begin
    n_chk = 0;
    n_fail = 0;
    //          r       busy sl rdy ce fd bo  led ci  bi seed
    tbl[0]  = '{0,       0,  0, 0,  0, 0, 0,  0,  0,  0, 4'h0};
    tbl[1]  = '{1,       1,  1, 0,  0, 0, 0,  0,  0,  0, 4'hA};
    tbl[2]  = '{2 + P,   1,  0, 1,  0, 0, PB, 0,  0,  0, 4'hA};
    tbl[3]  = '{3 + P,   1,  0, 0,  0, 0, 1,  0,  0,  0, 4'hA};
    tbl[4]  = '{4 + P,   1,  0, 0,  1, 0, 1,  0,  0,  0, 4'hA};
    tbl[5]  = '{5 + P,   1,  0, 0,  0, 0, 1,  0,  1,  0, 4'hA};
    tbl[6]  = '{32 + P,  1,  0, 0,  1, 0, 1,  0,  14, 0, 4'hA};
    tbl[7]  = '{33 + P,  1,  0, 1,  0, 0, 1,  0,  0,  1, 4'hA};
    tbl[8]  = '{34 + P,  1,  0, 0,  0, 0, 0,  0,  0,  1, 4'hA};
    tbl[9]  = '{250 + P, 1,  0, 0,  0, 1, 0,  0,  0,  7, 4'hA};
    tbl[10] = '{251 + P, 0,  0, 0,  0, 0, 0,  1,  0,  7, 4'hA};

    drive(1, 0, 0, 4'h0, 0, 0);
    repeat (3) @(negedge clk);
    drive(0, 0, 0, 4'h0, 0, 0);
    #1;
    chk("reset_state", dut_vec, 18'h0);
    @(negedge clk);

    // nominal frame, bits 1,0,1,1,0,0,1,0 with valid held high
    bits = 8'b0100_1101;
    ce_cnt = 0;
    for (int r = 0; r <= 251 + P; r++) begin
      if (r >= 2 + P) begin
        idx = (r - 2 - P) / 31;
        if (idx > 7) idx = 7;
        drive(0, r == 0, 0, 4'hA, bits[idx], 1);
      end else begin
        drive(0, r == 0, 0, 4'hA, 0, 1);
      end
      #1;
      for (int i = 0; i < 11; i++) if (tbl[i].r == r) check_row(tbl[i]);
      for (int b = 0; b < B; b++) if (r == 3 + P + 31 * b) chk("nom_bit_follow", bit_o, bits[b]);
      if (chip_en_o) ce_cnt++;
      @(negedge clk);
    end
    chk("nom_chip_count", ce_cnt, 120 + P / D);

    // reset held 3 cycles mid-RUN, then a fresh start is accepted
    for (int r = 0; r <= 47; r++) begin
      drive(r >= 40 && r <= 42, r == 0 || r == 44, r == 46, (r == 44) ? 4'h6 : 4'hC, 1, 1);
      #1;
      if (r == 43) chk("rst_all_zero", dut_vec, 18'h0);
      if (r == 45) begin
        chk("rst_restart_load", seed_load_o, 1);
        chk("rst_restart_seed", seed_o, 4'h6);
      end
      if (r == 47) chk("rst_abort_idle", busy_o, 0);
      @(negedge clk);
    end

    // starvation before bit 3
    ce_cnt = 0; win_cnt = 0; fd_cnt = 0;
    for (int r = 0; r <= 271 + P; r++) begin
      drive(0, r == 0, 0, 4'h5, 0, !(r >= 95 + P && r < 115 + P));
      #1;
      if (r == 100 + P) begin
        chk("starve_ready", bit_ready_o, 1);
        chk("starve_bit_idx", bit_idx_o, 3);
        chk("starve_busy", busy_o, 1);
      end
      if (chip_en_o) begin
        ce_cnt++;
        if (r >= 95 + P && r < 115 + P) win_cnt++;
      end
      if (frame_done_o) fd_cnt++;
      if (r == 270 + P) chk("starve_done_time", frame_done_o, 1);
      if (r == 271 + P) chk("starve_led", led_o, 1);
      @(negedge clk);
    end
    chk("starve_no_chips", win_cnt, 0);
    chk("starve_chip_count", ce_cnt, 120 + P / D);
    chk("starve_done_count", fd_cnt, 1);

    // abort at bit 5 chip 7, with an ignored start mid-frame
    fd_cnt = 0;
    for (int r = 0; r <= 260 + P; r++) begin
      drive(0, r == 0 || r == 50 + P, r == 172 + P, (r == 50 + P) ? 4'h5 : 4'h3, 1, 1);
      #1;
      if (r == 60 + P) chk("midframe_start_seed", seed_o, 4'h3);
      if (r == 172 + P) begin
        chk("abort_chip_idx", chip_idx_o, 7);
        chk("abort_bit_idx", bit_idx_o, 5);
      end
      if (r == 173 + P) begin
        chk("abort_busy", busy_o, 0);
        chk("abort_seed_hold", seed_o, 4'h3);
        chk("abort_bit_hold", bit_o, 1);
      end
      if (frame_done_o) fd_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", fd_cnt, 0);
    chk("abort_led_hold", led_o, 1);

    // start together with abort in IDLE
    drive(0, 1, 1, 4'h9, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 4'h0, 0, 0);
    #1;
    chk("start_abort_idle", busy_o, 0);
    chk("start_abort_seed", seed_o, 4'h3);
    @(negedge clk);

    // randomized run against the timeline model
    drive(1, 0, 0, 4'h0, 0, 0);
    m_step(1, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    for (int n = 0; n < 8000; n++) begin
      r_set = ($urandom_range(0, 1999) == 0);
      r_st  = ($urandom_range(0, 19) == 0);
      r_ab  = ($urandom_range(0, 999) == 0);
      r_sd  = 4'($urandom_range(0, 15));
      r_b   = 1'($urandom_range(0, 1));
      r_v   = ($urandom_range(0, 3) != 0);
      drive(r_set, r_st, r_ab, r_sd, r_b, r_v);
      #1;
      chk("random_outputs", dut_vec, m_out(r_ab));
      m_step(r_set, r_st, r_ab, r_sd, r_b, r_v);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
